serial_tx_sequencer: RTL and testbench
======================================

// Module: serial_tx_sequencer
//
// PURPOSE
//   Sequencer for an 8-bit shift-left register with parallel load, clock enable, serial-in and MSB serial-out.
//   Accepts one byte per valid/ready handshake and pulses LOAD once.
//   Then issues one shift enable per bit period, so each bit, MSB first, holds on SO for DIV clocks.
//   Sits between a byte source (FIFO/FSM) and the shift register that drives an output pin.
//
// PARAMETERS
//   DIV   4  clocks per bit period; legal range 1..65535
//   GAP   0  idle clocks inserted after each frame before tx_ready returns; legal range 0..255
//
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst_n      in   1  asynchronous active-low reset
//   tx_data    in   8  byte to send, sampled on handshake
//   tx_valid   in   1  source has a byte
//   tx_ready   out  1  sequencer can accept a byte (handshake = tx_valid & tx_ready at posedge)
//   sr_pdata   out  8  parallel data to the shift register
//   sr_load    out  1  shift-register LOAD (priority over shift)
//   sr_ce      out  1  shift-register clock enable (shift when sr_load=0)
//   sr_si      out  1  shift-register serial-in
//   tx_active  out  1  frame in progress (LOAD and SHIFT states)
//   tx_done    out  1  one-clock pulse when the last bit period of a frame ends
//
// BEHAVIOUR
//   - FSM states: IDLE, LOAD, SHIFT, GAP.
//     - tx_ready = (state==IDLE), decoded combinationally.
//     - tx_ready reads 1 during and after reset.
//   - rst_n low (asynchronous, any time, including mid-frame):
//     - state=IDLE.
//     - counters=0.
//     - sr_pdata=8'h00.
//     - sr_load, sr_ce, sr_si, tx_active, tx_done all 0.
//     - No partial frame resumes after reset.
//   - IDLE -> LOAD on handshake: tx_data is captured into sr_pdata.
//   - LOAD (exactly 1 clock):
//     - sr_load=1, sr_ce=1, tx_active=1.
//     - -> SHIFT with div_cnt=0, bit_cnt=0.
//     - Data bit 7 is on SO from the LOAD->SHIFT edge.
//   - SHIFT:
//     - div_cnt counts 0..DIV-1.
//     - sr_ce=1 only in the cycle where div_cnt==DIV-1; div_cnt then wraps to 0 and bit_cnt increments.
//     - When the 8th bit period ends (bit_cnt==7 and div_cnt==DIV-1), tx_done=1 for that cycle.
//     - Next state: GAP, or IDLE if GAP==0.
//     - DIV==1: sr_ce=1 every SHIFT cycle and the frame lasts 8 clocks.
//   - Frame length: 8*DIV clocks from the LOAD->SHIFT edge.
//     - Handshake-to-handshake spacing with tx_valid held high: 8*DIV+GAP+2 clocks.
//   - GAP: counts GAP clocks with all strobes 0, then -> IDLE.
//   - sr_si is 0 at all times (without the option below).
//     - Bits shifted in are zeros; the register reads 8'h00 after a full frame.
//   - tx_valid while not IDLE: ignored; tx_data is not sampled.
//     - tx_data changing mid-frame has no effect.
//   - Counters: div_cnt is 16 bits, bit_cnt is 4 bits, gap_cnt is 8 bits; none can overflow in legal ranges.
//   - Outputs sr_load, sr_ce, sr_si, tx_done, tx_active are decoded from registered state/counters; no input-to-output combinational path except none (tx_ready depends on state only).
//
// CONFIGURATION
//   SERIAL_TX_SEQ_PARITY_EN defined:
//     - Each frame carries 9 bit periods: 8 data bits then 1 even-parity bit (^tx_data captured on handshake).
//     - sr_si = parity during the first SHIFT-state sr_ce; 0 otherwise.
//       - After 8 shifts, the parity bit sits in the MSB and is on SO for the 9th period.
//     - tx_done fires at the end of the 9th period.
//     - Frame length is 9*DIV; handshake spacing is 9*DIV+GAP+2.
//   SERIAL_TX_SEQ_PARITY_EN undefined:
//     - 8-bit frames as above; no parity logic is synthesized.
//
// TESTING
//   Bench models the enabled shift register (load > ce-shift) and checks SO.
//   1. DIV=4, GAP=0, send 8'hA5 -> SO = 1,0,1,0,0,1,0,1, each held 4 clocks; tx_done exactly 33 clocks after the handshake edge.
//   2. rst_n pulsed low 10 clocks into a frame -> outputs 0 and tx_ready=1 immediately; the next handshake sends a clean full frame.
//   3. DIV=4, GAP=2, tx_valid held high, bytes 8'h3C then 8'hC3 -> handshakes 36 clocks apart; SO shows 00111100 then 11000011.
//   4. tx_valid pulsed with 8'hFF mid-frame of 8'h0F -> 8'hFF never appears on SO; tx_ready stays 0 until the frame and GAP end.
//   5. DIV=1, send 8'h81 -> SO = 1,0,0,0,0,0,0,1 over 8 consecutive clocks; sr_ce high for all 8 SHIFT cycles.
//   6. Build with SERIAL_TX_SEQ_PARITY_EN, DIV=2, send 8'h07 -> 9 bits 0,0,0,0,0,1,1,1,1 (parity=1); tx_done 19 clocks after the handshake.

Source files
------------

// File: rtl/serial_tx_sequencer.sv
// serial_tx_sequencer
//   Sequences an external 8-bit shift-left register. The register has
//   parallel load, clock enable, serial-in and MSB serial-out.
//   One byte is accepted per valid/ready handshake. The sequencer then
//   pulses LOAD once and issues one shift enable per bit period of DIV
//   clocks, so each bit is presented on SO MSB first.
//
// Parameters
//   DIV  clocks per bit period (1..65535)
//   GAP  idle clocks after each frame before tx_ready returns (0..255)
//
// Optional feature (compile-time macro SERIAL_TX_SEQ_PARITY_EN)
//   When the macro is defined, each frame gets a ninth bit period that
//   carries even parity of the captured byte. The parity bit is fed in
//   on sr_si at the first shift, so it reaches the MSB after 8 shifts.
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   tx_data    in   [7:0] byte to send, sampled on handshake
//   tx_valid   in   source has a byte
//   tx_ready   out  sequencer idle, can accept a byte
//   sr_pdata   out  [7:0] parallel data to the shift register
//   sr_load    out  shift-register LOAD
//   sr_ce      out  shift-register clock enable
//   sr_si      out  shift-register serial-in
//   tx_active  out  frame in progress (LOAD and SHIFT states)
//   tx_done    out  one-clock pulse as the last bit period ends
module serial_tx_sequencer #(
  parameter int DIV = 4,
  parameter int GAP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] sr_pdata,
  output logic       sr_load,
  output logic       sr_ce,
  output logic       sr_si,
  output logic       tx_active,
  output logic       tx_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [7:0]  GAP_M1 = 8'(GAP - 1);

`ifdef SERIAL_TX_SEQ_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  logic [1:0]  state_q,   state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  pdata_q,   pdata_d;
  logic        bit_end;

`ifdef SERIAL_TX_SEQ_PARITY_EN
  logic parity_q, parity_d;
`endif

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pdata_d   = pdata_q;
`ifdef SERIAL_TX_SEQ_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_LOAD;
          pdata_d = tx_data;
`ifdef SERIAL_TX_SEQ_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        div_cnt_d = '0;
        bit_cnt_d = '0;
      end
      S_SHIFT: begin
        if (div_cnt_q == DIV_M1) begin
          div_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = (GAP == 0) ? S_IDLE : S_GAP;
            gap_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_M1) state_d = S_IDLE;
        else                     gap_cnt_d = gap_cnt_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      pdata_q   <= '0;
`ifdef SERIAL_TX_SEQ_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pdata_q   <= pdata_d;
`ifdef SERIAL_TX_SEQ_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Last clock of a bit period: the shift happens on the following edge.
  assign bit_end   = (state_q == S_SHIFT) && (div_cnt_q == DIV_M1);

  assign tx_ready  = (state_q == S_IDLE);
  assign sr_load   = (state_q == S_LOAD);
  // CE is also raised during LOAD; LOAD has priority in the register.
  assign sr_ce     = (state_q == S_LOAD) || bit_end;
  assign tx_active = (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign tx_done   = bit_end && (bit_cnt_q == LAST_BIT);
  assign sr_pdata  = pdata_q;

`ifdef SERIAL_TX_SEQ_PARITY_EN
  assign sr_si = bit_end && (bit_cnt_q == 4'd0) && parity_q;
`else
  assign sr_si = 1'b0;
`endif

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// tb_serial_tx_sequencer
//   Three sequencer instances with different DIV/GAP share a clock and a
//   reset. Each instance drives its own shift-register model. The expected
//   SO stream of a frame comes from the byte value itself (MSB first, plus
//   parity when SERIAL_TX_SEQ_PARITY_EN is defined).
module tb_serial_tx_sequencer;

`ifdef SERIAL_TX_SEQ_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]      tx_valid, tx_ready, sr_load, sr_ce, sr_si, tx_active, tx_done;
  logic [7:0]      tx_data [3];
  logic [2:0][7:0] sr_pdata;
  logic [2:0][7:0] sr;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int divs [3] = '{4, 4, 1};
  int gaps [3] = '{0, 2, 0};
  int last_hs [3] = '{0, 0, 0};

  serial_tx_sequencer #(.DIV(4), .GAP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .sr_pdata(sr_pdata[0]), .sr_load(sr_load[0]),
    .sr_ce(sr_ce[0]), .sr_si(sr_si[0]), .tx_active(tx_active[0]), .tx_done(tx_done[0]));

  serial_tx_sequencer #(.DIV(4), .GAP(2)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .sr_pdata(sr_pdata[1]), .sr_load(sr_load[1]),
    .sr_ce(sr_ce[1]), .sr_si(sr_si[1]), .tx_active(tx_active[1]), .tx_done(tx_done[1]));

  serial_tx_sequencer #(.DIV(1), .GAP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .sr_pdata(sr_pdata[2]), .sr_load(sr_load[2]),
    .sr_ce(sr_ce[2]), .sr_si(sr_si[2]), .tx_active(tx_active[2]), .tx_done(tx_done[2]));

  // External shift registers: load beats clock-enabled shift-left.
  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (sr_load[k])    sr[k] <= sr_pdata[k];
      else if (sr_ce[k]) sr[k] <= {sr[k][6:0], sr_si[k]};
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the frame for byte b, MSB first; index 8 is the parity bit.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i < 8) return b[7 - i];
    return ^b;
  endfunction

  // Called and returns at a negedge. abort_at/junk_at of 0 disable those actions.
  task automatic send(input int k, input logic [7:0] b, input logic [7:0] nxt,
                      input bit hold, input bit chk_sp, input int abort_at,
                      input int junk_at);
    int w;
    int d;
    int g;
    d = divs[k];
    g = gaps[k];
    w = 0;
    while (!tx_ready[k] && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready[k]) begin
      chk("ready_timeout", 16'(tx_ready[k]), 16'd1);
      return;
    end
    tx_data[k]  = b;
    tx_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (chk_sp) chk("hs_spacing", 16'(cyc - last_hs[k]), 16'(NB * d + g + 2));
    last_hs[k] = cyc;
    chk("load",       16'(sr_load[k]),   16'd1);
    chk("load_act",   16'(tx_active[k]), 16'd1);
    chk("load_ready", 16'(tx_ready[k]),  16'd0);
    chk("pdata",      16'(sr_pdata[k]),  16'(b));
    if (hold) tx_data[k] = nxt;
    else      tx_valid[k] = 1'b0;
    for (int n = 1; n <= NB * d; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ready",  16'(tx_ready[k]),  16'd1);
        chk("rst_load",   16'(sr_load[k]),   16'd0);
        chk("rst_ce",     16'(sr_ce[k]),     16'd0);
        chk("rst_si",     16'(sr_si[k]),     16'd0);
        chk("rst_active", 16'(tx_active[k]), 16'd0);
        chk("rst_done",   16'(tx_done[k]),   16'd0);
        chk("rst_pdata",  16'(sr_pdata[k]),  16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (junk_at != 0 && n == junk_at) begin
        tx_valid[k] = 1'b1;
        tx_data[k]  = 8'hFF;
      end
      if (junk_at != 0 && n == junk_at + 1) tx_valid[k] = 1'b0;
      chk("so",     16'(sr[k][7]),     16'(exp_bit(b, (n - 1) / d)));
      chk("done",   16'(tx_done[k]),   16'(n == NB * d));
      chk("ce",     16'(sr_ce[k]),     16'(n % d == 0));
      chk("ready",  16'(tx_ready[k]),  16'd0);
      chk("active", 16'(tx_active[k]), 16'd1);
      chk("load0",  16'(sr_load[k]),   16'd0);
    end
    for (int m = 1; m <= g; m++) begin
      @(negedge clk);
      chk("gap_ready",  16'(tx_ready[k]),  16'd0);
      chk("gap_active", 16'(tx_active[k]), 16'd0);
      chk("gap_strobe", 16'({sr_ce[k], sr_load[k], tx_done[k], sr_si[k]}), 16'd0);
    end
    @(negedge clk);
    chk("idle_ready", 16'(tx_ready[k]), 16'd1);
    chk("flushed",    16'(sr[k]),       16'd0);
  endtask

  initial begin
    logic [7:0] r0;
    logic [7:0] r1;
    rst_n    = 1'b0;
    tx_valid = '0;
    for (int k = 0; k < 3; k++) tx_data[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready",  16'(tx_ready[k]),  16'd1);
      chk("reset_strobe", 16'({sr_load[k], sr_ce[k], sr_si[k], tx_active[k], tx_done[k]}), 16'd0);
      chk("reset_pdata",  16'(sr_pdata[k]),  16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // DIV=4 GAP=0: 8'hA5
    send(0, 8'hA5, 8'h00, 1'b0, 1'b0, 0, 0);
    // Reset 10 clocks into a frame, then a clean frame
    r0 = 8'($urandom);
    send(0, r0, 8'h00, 1'b0, 1'b0, 10, 0);
    send(0, 8'($urandom), 8'h00, 1'b0, 1'b0, 0, 0);
    // DIV=4 GAP=2, valid held: 3C then C3, spacing checked
    send(1, 8'h3C, 8'hC3, 1'b1, 1'b0, 0, 0);
    send(1, 8'hC3, 8'h00, 1'b0, 1'b1, 0, 0);
    // Mid-frame junk byte ignored
    send(1, 8'h0F, 8'h00, 1'b0, 1'b0, 0, 6);
    // DIV=1: 8'h81
    send(2, 8'h81, 8'h00, 1'b0, 1'b0, 0, 0);
    // Randomized frames, with back-to-back held pairs
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        r0 = 8'($urandom);
        r1 = 8'($urandom);
        send(k, r0, r1, 1'b1, 1'b0, 0, 0);
        send(k, r1, 8'h00, 1'b0, 1'b1, 0, int'($urandom_range(0, 3)));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
